// File: rtl/dmem_ctrl.sv
// Data-memory controller: RV32I byte/half/word loads and stores behind a
// req/busy/done handshake with configurable wait states and fault detection.
module dmem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               we_q, we_nxt;
  logic [2:0]         f3_q, f3_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [1:0]         lane_q, lane_nxt;
  logic [31:0]        wdata_q, wdata_nxt;
  logic               err_nxt;
  logic [31:0]        rdata_nxt;

  logic               legal_c, misal_c, oor_c, fault_c;
  logic               mem_we_c;
  logic [3:0]         be_c;
  logic [31:0]        wd_c;
  logic [31:0]        rword_c;
  logic [31:0]        load_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;

  logic [31:0]        mem [DEPTH];

  // Classify the incoming request; all three fault kinds share one outcome
  always_comb begin
    legal_c = we ? (funct3 <= 3'd2)
                 : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
              ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oor_c   = 64'(addr[ADDR_W-1:2]) >= 64'(DEPTH);
    fault_c = !legal_c || misal_c || oor_c;
  end

  // Load lane extraction and extension from the latched request
  always_comb begin
    rword_c = mem[idx_q];
    byte_c  = rword_c[{lane_q, 3'b000} +: 8];
    half_c  = rword_c[{lane_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_c = {{24{!f3_q[2] && byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{!f3_q[2] && half_c[15]}}, half_c};
      default: load_c = rword_c;
    endcase
  end

  // Store byte enables with data replicated across lanes
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_c = 4'b0001 << lane_q;
        wd_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c = lane_q[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_q;
      end
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    f3_nxt    = f3_q;
    idx_nxt   = idx_q;
    lane_nxt  = lane_q;
    wdata_nxt = wdata_q;
    err_nxt   = err;
    rdata_nxt = rdata;
    mem_we_c  = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (req) begin
          we_nxt    = we;
          f3_nxt    = funct3;
          idx_nxt   = addr[IDX_W+1:2];
          lane_nxt  = addr[1:0];
          wdata_nxt = wdata;
          if (fault_c) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
            if (!we) rdata_nxt = 32'd0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = RESP;
          err_nxt   = 1'b0;
          if (we_q) mem_we_c  = 1'b1;
          else      rdata_nxt = load_c;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      we_q    <= we_nxt;
      f3_q    <= f3_nxt;
      idx_q   <= idx_nxt;
      lane_q  <= lane_nxt;
      wdata_q <= wdata_nxt;
      err     <= err_nxt;
      rdata   <= rdata_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == RESP);
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_q][8*i +: 8] <= wd_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, randomized and
// directed accesses, reset abort, and back-to-back latency at several wait counts.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned W_MAIN = 2;
  localparam int unsigned NRAND  = 300;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;

  logic        req0, req5;
  logic        busy0, done0, err0, busy5, done5, err5;
  logic [31:0] rdata0, rdata5;
  logic        ax_we;
  logic [2:0]  ax_f3;
  logic [31:0] ax_addr, ax_wdata;

  exp_t        sb[$];
  exp_t        e_mon;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rst_test = 1'b0;
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W_MAIN), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata));

  dmem_ctrl #(.DEPTH(16), .WAIT_CYCLES(0), .ADDR_W(32)) dut_w0 (
    .clk(clk), .reset(reset), .req(req0), .we(ax_we), .funct3(ax_f3), .addr(ax_addr),
    .wdata(ax_wdata), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0));

  dmem_ctrl #(.DEPTH(16), .WAIT_CYCLES(5), .ADDR_W(32)) dut_w5 (
    .clk(clk), .reset(reset), .req(req5), .we(ax_we), .funct3(ax_f3), .addr(ax_addr),
    .wdata(ax_wdata), .busy(busy5), .done(done5), .err(err5), .rdata(rdata5));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, got, want);
    end
  endtask

  function automatic bit is_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    bit legal, misal, oor;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    oor   = (a >> 2) >= DEPTH;
    return !legal || misal || oor;
  endfunction

  // Monitor: busy must track outstanding requests; each done pops one expectation
  always @(negedge clk) begin
    if (reset && !rst_test) begin
      chk("busy_track", 32'(busy), 32'(sb.size() != 0));
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done @cyc %0d: done=1 with nothing outstanding", cyc);
        end else begin
          e_mon = sb.pop_front();
          chk("err", 32'(err), 32'(e_mon.err));
          chk("rdata", rdata, e_mon.rdata);
          chk("done_cycle", 32'(cyc), 32'(e_mon.cyc));
        end
      end
    end
  end

  // Present one request in an accepting cycle and queue its predicted response
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_lit, input logic [31:0] lit);
    int budget;
    int n;
    bit f;
    logic [31:0] v;
    exp_t e;
    budget = 0;
    @(negedge clk);
    while (busy && !done && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout @cyc %0d: controller never accepted", cyc);
    end
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    f = is_fault(w, f3, a);
    n = 1 << f3[1:0];
    if (f) begin
      if (!w) ref_rdata = 32'd0;
    end else if (w) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      ref_rdata = v;
    end
    e.err   = f;
    e.rdata = use_lit ? lit : ref_rdata;
    e.cyc   = cyc + (f ? 0 : int'(W_MAIN) + 1);
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Store abandoned by reset while still counting wait states
  task automatic reset_mid_store();
    drain();
    rst_test = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    ref_rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rst_test = 1'b0;
  endtask

  // Three good loads with req held high; done spacing must be exactly w+2
  task automatic b2b(input int k, input int w);
    int first, seen, budget;
    logic d, b, e;
    @(negedge clk);
    if (k == 0) req0 = 1'b1; else req5 = 1'b1;
    @(posedge clk);
    #1;
    first = cyc;
    seen = 0;
    budget = 0;
    while (seen < 3 && budget < 200) begin
      @(negedge clk);
      budget++;
      d = (k == 0) ? done0 : done5;
      b = (k == 0) ? busy0 : busy5;
      e = (k == 0) ? err0 : err5;
      chk($sformatf("b2b_w%0d_busy", w), 32'(b), 32'd1);
      if (d) begin
        seen++;
        chk($sformatf("b2b_w%0d_err", w), 32'(e), 32'd0);
        chk($sformatf("b2b_w%0d_done_cycle", w), 32'(cyc), 32'(first + w + 1 + (seen - 1) * (w + 2)));
        if (seen == 3) begin
          if (k == 0) req0 = 1'b0; else req5 = 1'b0;
        end
      end
    end
    if (seen < 3) begin
      checks++;
      errors++;
      $display("FAIL b2b_w%0d_timeout: saw %0d of 3 done pulses", w, seen);
    end
    @(negedge clk);
    b = (k == 0) ? busy0 : busy5;
    chk($sformatf("b2b_w%0d_idle", w), 32'(b), 32'd0);
  endtask

  initial begin
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] ra;
    int          sel;
    reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; req5 = 1'b0;
    ax_we = 1'b0; ax_f3 = 3'd2; ax_addr = 32'h4; ax_wdata = 32'd0;
    ref_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    chk("init_rdata", rdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) issue(1'b1, 3'd2, 32'(i * 4), 32'd0, 1'b0, 32'd0);

    issue(1'b1, 3'd2, 32'h10, 32'h12345678, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h12345678);
    issue(1'b1, 3'd0, 32'h11, 32'h000000AB, 1'b0, 32'd0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234AB78);
    issue(1'b0, 3'd0, 32'h11, 32'd0, 1'b1, 32'hFFFFFFAB);
    issue(1'b0, 3'd4, 32'h11, 32'd0, 1'b1, 32'h000000AB);
    issue(1'b0, 3'd1, 32'h12, 32'd0, 1'b1, 32'h00001234);
    issue(1'b1, 3'd1, 32'h13, 32'h0000CAFE, 1'b1, 32'h00001234);
    issue(1'b0, 3'd2, 32'h12, 32'd0, 1'b1, 32'd0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234AB78);
    issue(1'b0, 3'd2, 32'h400, 32'd0, 1'b1, 32'd0);
    issue(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1, 32'd0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b1, 32'h1234AB78);

    reset_mid_store();
    issue(1'b0, 3'd2, 32'h20, 32'd0, 1'b1, 32'd0);

    for (int k = 0; k < int'(NRAND); k++) begin
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = $urandom;
      else if (sel == 1) ra = 32'(DEPTH * 4 + $urandom_range(0, 15));
      else               ra = 32'($urandom_range(0, 63));
      issue(rw, rf3, ra, $urandom, 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    b2b(0, 0);
    b2b(1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the single-cycle RISC-V core, replacing the bench-modelled zero-latency word array.
- Supports RV32I byte, halfword and word loads and stores, with sign and zero extension.
- Detects misaligned, illegal and out-of-range accesses.
- Models a configurable number of wait states behind a req/busy/done handshake, so the datapath must stall on memory operations.
- Sits between the datapath's ALUResult/WriteData/MemWrite signals and the core's load writeback path.

## Interface
- DEPTH, 256: memory size in 32-bit words; any value ≥1.
- WAIT_CYCLES, 2: extra access latency in clocks; legal range 0..15.
- ADDR_W, 32: byte-address width.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only when accepting (see Operation).
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RV32I width code; sampled with req.
- addr  in  ADDR_W  byte address; sampled with req.
- wdata  in  32  store data, right-aligned; sampled with req.
- busy  out  1  high while a request is in flight, including the response cycle; the core stalls on it.
- done  out  1  one-cycle pulse marking the response cycle.
- err  out  1  response is a fault; valid only while done=1.
- rdata  out  32  extended load result; updated on a successful load, held otherwise.

## Operation
- States: IDLE, WAIT, RESP.
  - busy = (state != IDLE).
  - done = (state == RESP).
- Acceptance: req=1 is accepted in IDLE or RESP. In WAIT, req is ignored and nothing is queued.
- On accept, latch we, funct3, addr and wdata, then check the request in this order:
  - Illegal funct3 is a fault.
    - Loads allow 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores allow 000 SB, 001 SH, 010 SW.
  - Misalignment is a fault: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - Out of range is a fault: word index addr[ADDR_W-1:2] ≥ DEPTH.
- Faulting request: next state RESP with err=1. Memory is not touched. rdata is forced to 0 for a faulting load and unchanged for a faulting store.
- Good request: next state WAIT, wait counter loaded with WAIT_CYCLES.
- WAIT, per edge:
  - If counter ≠ 0: decrement it.
  - If counter = 0: perform the access, set err=0, go to RESP.
- Store lanes:
  - SB writes wdata[7:0] to byte lane addr[1:0].
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Other lanes are preserved.
- Load extraction: select the lane by addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- RESP: if req=1, accept as above; otherwise go to IDLE.
- Byte ordering is little-endian: lane 0 is bits [7:0].
- The memory array is not cleared by reset.

## Timing
- Reset (asynchronous assert): state=IDLE, busy=0, done=0, err=0, rdata=0, counter=0.
- Reset mid-operation: any in-flight request is abandoned. A store still in WAIT never writes. Release is synchronous to the next edge.
- Good access latency: accepted at edge E0, the memory is written or read at edge E0+WAIT_CYCLES+1, and done is high in the cycle after that edge.
  - With WAIT_CYCLES=0, done is high in the second cycle after acceptance.
- Fault latency: done is high in the cycle immediately after the accepting edge.
- Back-to-back: with req held high, a new request is accepted in the RESP cycle. busy stays high and done pulses once per request.
- rdata and err change only at the edge entering RESP and are stable throughout RESP.
- Throughput: one access per WAIT_CYCLES+2 cycles.

## Test plan
- WAIT_CYCLES=2, SW 0x12345678 at 0x10, then LW 0x10 → busy high from the accept edge; done pulses 3 edges after accept; rdata=0x12345678; err=0.
- SB 0xAB at 0x11 onto 0x12345678 → LW 0x10 returns 0x1234AB78; LB 0x11 returns 0xFFFFFFAB; LBU 0x11 returns 0x000000AB; LH 0x12 returns 0x00001234.
- SH at 0x13 and LW at 0x12 → each gives done with err=1 one cycle after accept; the following LW 0x10 still returns 0x1234AB78.
- DEPTH=256: LW at 0x400 → err=1 and rdata=0. Store funct3=011 → err=1 with no memory change.
- SW 0xDEADBEEF at 0x20 (prior value 0), reset pulled low during WAIT → busy, done, err and rdata all 0 immediately; a later LW 0x20 returns 0.
- req held high across three good loads with WAIT_CYCLES=0 → done pulses every second cycle and busy never drops; repeat with WAIT_CYCLES=0 and WAIT_CYCLES=5 to confirm latency scales exactly.
